// File: rtl/power_seq_ctrl.sv
// Power-up/power-down sequencer for an OV5640-class camera sensor (PWDN, RESETB, ready flag).
// Define POWER_SEQ_XCLK_GATE_EN to add the cam_xclk_en sensor clock gate output.
module power_seq_ctrl #(
  parameter int unsigned T_PWDN = 300000,
  parameter int unsigned T_RST  = 100000,
  parameter int unsigned T_INIT = 1050000,
  parameter int unsigned T_OFF  = 1000,
  parameter int unsigned CNT_W  = 21
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic pwr_en,
  output logic cam_pwdn,
  output logic cam_rst_n,
  output logic power_done,
  output logic busy
`ifdef POWER_SEQ_XCLK_GATE_EN
  ,
  output logic cam_xclk_en
`endif
);

  localparam int unsigned IdxOff  = 0;
  localparam int unsigned IdxPwdn = 1;
  localparam int unsigned IdxRst  = 2;
  localparam int unsigned IdxInit = 3;
  localparam int unsigned IdxOn   = 4;
  localparam int unsigned IdxDown = 5;

  localparam logic [5:0] StOff  = 6'b000001;
  localparam logic [5:0] StPwdn = 6'b000010;
  localparam logic [5:0] StRst  = 6'b000100;
  localparam logic [5:0] StInit = 6'b001000;
  localparam logic [5:0] StOn   = 6'b010000;
  localparam logic [5:0] StDown = 6'b100000;

  // Terminal counts: a timed state lasts exactly T_x cycles, counting 0 .. T_x-1.
  localparam logic [CNT_W-1:0] PwdnLast = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0] RstLast  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] InitLast = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] OffLast  = CNT_W'(T_OFF - 1);

  logic [5:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed;
  logic             pwdn_q, pwdn_d;
  logic             rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Aborts are tested before the terminal count so they win in a tie.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[IdxOff]: begin
        if (pwr_en) state_d = StPwdn;
      end
      state_q[IdxPwdn]: begin
        if (!pwr_en)                state_d = StOff;
        else if (cnt_q == PwdnLast) state_d = StRst;
      end
      state_q[IdxRst]: begin
        if (!pwr_en)               state_d = StDown;
        else if (cnt_q == RstLast) state_d = StInit;
      end
      state_q[IdxInit]: begin
        if (!pwr_en)                state_d = StDown;
        else if (cnt_q == InitLast) state_d = StOn;
      end
      state_q[IdxOn]: begin
        if (!pwr_en) state_d = StDown;
      end
      state_q[IdxDown]: begin
        if (cnt_q == OffLast) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  assign timed = state_q[IdxPwdn] | state_q[IdxRst] | state_q[IdxInit] | state_q[IdxDown];

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (timed)         cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    pwdn_d  = state_d[IdxOff] | state_d[IdxPwdn];
    rst_n_d = state_d[IdxInit] | state_d[IdxOn];
    done_d  = state_d[IdxOn];
    busy_d  = state_d[IdxPwdn] | state_d[IdxRst] | state_d[IdxInit] | state_d[IdxDown];
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      pwdn_q  <= 1'b1;
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwdn_q  <= pwdn_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign cam_pwdn   = pwdn_q;
  assign cam_rst_n  = rst_n_q;
  assign power_done = done_q;
  assign busy       = busy_q;

`ifdef POWER_SEQ_XCLK_GATE_EN
  logic xclk_q, xclk_d;

  // Clock runs through all of RST and DOWN so RESETB edges see a live XCLK.
  assign xclk_d = state_d[IdxRst] | state_d[IdxInit] | state_d[IdxOn] | state_d[IdxDown];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) xclk_q <= 1'b0;
    else          xclk_q <= xclk_d;
  end

  assign cam_xclk_en = xclk_q;
`endif

endmodule

// File: doc/power_seq_ctrl.md
# power_seq_ctrl

Parametrised power-up and power-down sequencer for a CMOS camera sensor (OV5640 class). It drives the sensor PWDN and RESETB pins and reports when the sensor is ready for SCCB configuration. All sequence delays are parameters, and the sensor can be powered down and back up at run time through a level request. It sits between the board clock/reset and the SCCB configuration block, which starts only while `power_done` is high.

## Interface
Parameters:
- `T_PWDN`, default 300000: cycles PWDN is held high after power-up is requested (6 ms at 50 MHz).
- `T_RST`, default 100000: cycles with PWDN low and RESETB low (2 ms).
- `T_INIT`, default 1050000: cycles after RESETB release before `power_done` (21 ms).
- `T_OFF`, default 1000: cycles RESETB is held low before PWDN is reasserted on power-down (20 µs).
- `CNT_W`, default 21: delay counter width. Every `T_*` must be ≥1 and ≤2^CNT_W.

Ports:
- `sclk` input 1: system clock, 50 MHz nominal. The block has one clock.
- `s_rst_n` input 1: asynchronous, active-low reset.
- `pwr_en` input 1: level request. 1 means the sensor should be on, 0 means off. Synchronous to `sclk`.
- `cam_pwdn` output 1: sensor PWDN pin, active high.
- `cam_rst_n` output 1: sensor RESETB pin, active low.
- `power_done` output 1: high only in state ON.
- `busy` output 1: high in PWDN, RST, INIT and DOWN.

## Operation
- The state register is one-hot. There are six states: OFF, PWDN, RST, INIT, ON, DOWN.
- All outputs are registers loaded together with the state.

Output values per state:
- OFF: pwdn=1, rst_n=0, done=0, busy=0.
- PWDN: pwdn=1, rst_n=0, busy=1.
- RST: pwdn=0, rst_n=0, busy=1.
- INIT: pwdn=0, rst_n=1, busy=1.
- ON: pwdn=0, rst_n=1, done=1, busy=0.
- DOWN: pwdn=0, rst_n=0, busy=1.

Counter:
- `cnt` (CNT_W bits) clears on every state change.
- It increments each cycle spent in a timed state.
- A timed state exits when `cnt == T_x-1`. `cnt` never wraps.

Transitions, evaluated each cycle:
- OFF: if `pwr_en`=1, go to PWDN.
- PWDN: if `pwr_en`=0, go to OFF (abort). Else at `T_PWDN-1`, go to RST.
- RST: if `pwr_en`=0, go to DOWN. Else at `T_RST-1`, go to INIT.
- INIT: if `pwr_en`=0, go to DOWN. Else at `T_INIT-1`, go to ON.
- ON: if `pwr_en`=0, go to DOWN.
- DOWN: at `T_OFF-1`, go to OFF. `pwr_en` is ignored throughout DOWN.

Rules:
- Abort has priority over a timer exit that expires in the same cycle.
- After DOWN completes, a still-high `pwr_en` starts a new power-up on the next cycle. It passes through OFF for exactly one cycle.
- Reset asserted mid-sequence forces OFF immediately, regardless of state. It clears `cnt` and all outputs.

## Timing
- Reset values: state=OFF, cnt=0, cam_pwdn=1, cam_rst_n=0, power_done=0, busy=0, cam_xclk_en=0.
- Suppose the edge at cycle k is the first edge that samples `pwr_en`=1 while in OFF. Then the state is:
  - PWDN during k+1 … k+T_PWDN,
  - RST during the next T_RST cycles,
  - INIT during the next T_INIT cycles,
  - ON from k+T_PWDN+T_RST+T_INIT+1.
- Power-down: `pwr_en` is sampled 0 in ON at edge j. The state is DOWN during j+1 … j+T_OFF and OFF from j+T_OFF+1.
- Latency from a `pwr_en` change to the first output change is one cycle.

## Configuration
- Macro `POWER_SEQ_XCLK_GATE_EN`, when defined, adds the output port `cam_xclk_en` (1 bit) for gating the sensor XCLK.
  - `cam_xclk_en` is 1 in RST, INIT, ON and DOWN, and 0 in OFF and PWDN.
  - The sensor clock therefore runs for the whole of T_RST before RESETB rises, and for the whole of T_OFF after RESETB falls.
  - It is registered with the other outputs and resets to 0.
- When the macro is not defined, the port does not exist and the sensor XCLK must be free-running. All other behaviour is identical.

## Test plan
All scenarios use T_PWDN=4, T_RST=3, T_INIT=5, T_OFF=2.
- **Power-up from reset:** hold `pwr_en`=1 and release reset, with the first sample at edge k. Required: pwdn falls at k+5, rst_n rises at k+8, power_done=1 from k+13, busy=1 over k+1…k+12.
- **Power-down from ON:** drop `pwr_en` at edge j. Required: rst_n=0 and power_done=0 at j+1, pwdn=1 at j+3, busy=1 over j+1…j+2.
- **Abort in PWDN:** drop `pwr_en` 2 cycles into PWDN. Required: OFF next cycle, pwdn never goes low, DOWN never entered. **Abort in INIT:** drop `pwr_en` in INIT. Required: DOWN for 2 cycles, then OFF.
- **Request during DOWN:** raise `pwr_en` in the first DOWN cycle. Required: DOWN completes its 2 cycles, OFF for 1 cycle, then PWDN, then a full power-up.
- **Reset mid-sequence:** assert `s_rst_n`=0 asynchronously in RST. Required: pwdn=1, rst_n=0, power_done=0 immediately. After release with `pwr_en`=1, a full 4/3/5 sequence is repeated.
- **Macro defined:** check `cam_xclk_en` is 0 in PWDN, rises on RST entry, stays 1 through ON and DOWN, and falls on OFF entry. **Macro undefined:** the scenarios above pass unchanged.
